// File: rtl/secure_router_pkg.sv
// Shared constants, lane state type and the Hamming(7,4) decoder for the
// receive side of the secure serial link.
package secure_router_pkg;

   localparam int FRAME_BITS = 7;
   localparam int NUM_LANES  = 4;

   // Hamming positions, numbered 1..7 in on-wire order (first bit = position 1)
   localparam int POS_P1 = 1;
   localparam int POS_P2 = 2;
   localparam int POS_D3 = 3;
   localparam int POS_P3 = 4;
   localparam int POS_D2 = 5;
   localparam int POS_D1 = 6;
   localparam int POS_D0 = 7;

   typedef enum logic {
      LANE_IDLE,
      LANE_RECV
   } lane_state_t;

   typedef struct packed {
      logic [3:0] nibble;
      logic [2:0] syndrome;
   } decode_t;

   function automatic decode_t hamming74_decode(input logic [FRAME_BITS-1:0] frame);
      logic [7:1] r;
      decode_t    res;
      for (int k = 1; k <= FRAME_BITS; k++) begin
         r[k] = frame[FRAME_BITS-k];
      end
      res.syndrome = {r[POS_P3] ^ r[POS_D2] ^ r[POS_D1] ^ r[POS_D0],
                      r[POS_P2] ^ r[POS_D3] ^ r[POS_D1] ^ r[POS_D0],
                      r[POS_P1] ^ r[POS_D3] ^ r[POS_D2] ^ r[POS_D0]};
      // A non-zero syndrome names the bit position to flip
      if (res.syndrome != 3'd0) begin
         r[res.syndrome] = ~r[res.syndrome];
      end
      res.nibble = {r[POS_D3], r[POS_D2], r[POS_D1], r[POS_D0]};
      return res;
   endfunction

endpackage

// File: rtl/secure_router_rx_if.sv
// Output word handshake of the receive router: {lane, nibble} plus the
// corrected flag behind valid/ready.
interface secure_router_rx_if;
   logic [5:0] data_out;
   logic       valid_out;
   logic       ready_in;
   logic       corrected_out;

   modport master (
      output data_out,
      output valid_out,
      output corrected_out,
      input  ready_in
   );

   modport slave (
      input  data_out,
      input  valid_out,
      input  corrected_out,
      output ready_in
   );
endinterface

// File: rtl/secure_rx_lane.sv
// One receive lane: deserializer FSM with gap timeout, Hamming decode and a
// one-entry buffer. SECURE_RX_CORRECT_EN enables single-bit correction.
import secure_router_pkg::*;

module secure_rx_lane #(
   parameter int GAP_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data,
   input  logic       strobe,
   input  logic       grant,
   output logic       full,
   output logic [3:0] nibble,
   output logic       corrected,
   output logic       overflow,
   output logic       timeout,
   output logic       err
);

   localparam logic [7:0] GAP_LIMIT = 8'(GAP_MAX);
   localparam logic [2:0] LAST_CNT  = 3'(FRAME_BITS - 1);

   lane_state_t                 state;
   logic [FRAME_BITS-2:0]       shift_reg;
   logic [2:0]                  bit_cnt;
   logic [7:0]                  gap_cnt;
   logic [FRAME_BITS-1:0]       frame_next;
   decode_t                     dec;
   logic                        frame_ok;
   logic                        frame_corr;

   assign frame_next = {shift_reg, data};
   assign dec        = hamming74_decode(frame_next);

`ifdef SECURE_RX_CORRECT_EN
   assign frame_ok   = 1'b1;
   assign frame_corr = (dec.syndrome != 3'd0);
`else
   assign frame_ok   = (dec.syndrome == 3'd0);
   assign frame_corr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LANE_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         full      <= 1'b0;
         nibble    <= '0;
         corrected <= 1'b0;
         overflow  <= 1'b0;
         timeout   <= 1'b0;
         err       <= 1'b0;
      end else begin
         overflow <= 1'b0;
         timeout  <= 1'b0;
         err      <= 1'b0;
         if (grant) begin
            full <= 1'b0;
         end
         case (state)
            LANE_IDLE: begin
               if (strobe) begin
                  shift_reg <= {{(FRAME_BITS-2){1'b0}}, data};
                  bit_cnt   <= 3'd1;
                  gap_cnt   <= '0;
                  state     <= LANE_RECV;
               end
            end
            LANE_RECV: begin
               // The abort wins over a strobe seen on the same edge
               if (gap_cnt == GAP_LIMIT) begin
                  timeout <= 1'b1;
                  gap_cnt <= '0;
                  state   <= LANE_IDLE;
               end else if (strobe) begin
                  shift_reg <= frame_next[FRAME_BITS-2:0];
                  bit_cnt   <= bit_cnt + 3'd1;
                  gap_cnt   <= '0;
                  if (bit_cnt == LAST_CNT) begin
                     state <= LANE_IDLE;
                     if (!frame_ok) begin
                        err <= 1'b1;
                     end else if (!full || grant) begin
                        full      <= 1'b1;
                        nibble    <= dec.nibble;
                        corrected <= frame_corr;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: state <= LANE_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/secure_router_rx.sv
// Four-lane secure serial receiver with round-robin output arbitration.
// Lane correction is selected by SECURE_RX_CORRECT_EN (see secure_rx_lane).
import secure_router_pkg::*;

module secure_router_rx #(
   parameter int GAP_MAX = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   data_in0,
   input  logic                   data_in1,
   input  logic                   data_in2,
   input  logic                   data_in3,
   input  logic                   strobe_in0,
   input  logic                   strobe_in1,
   input  logic                   strobe_in2,
   input  logic                   strobe_in3,
   secure_router_rx_if.master     out_bus,
   output logic [NUM_LANES-1:0]   overflow_out,
   output logic [NUM_LANES-1:0]   timeout_out,
   output logic [NUM_LANES-1:0]   err_out
);

   logic [NUM_LANES-1:0] lane_data;
   logic [NUM_LANES-1:0] lane_strobe;
   logic [NUM_LANES-1:0] full;
   logic [NUM_LANES-1:0] grant;
   logic [NUM_LANES-1:0] lane_corr;
   logic [3:0]           lane_nibble [NUM_LANES];
   logic [1:0]           rr_ptr;
   logic [1:0]           pick;
   logic [1:0]           idx;
   logic                 any_full;
   logic                 out_free;

   assign lane_data   = {data_in3, data_in2, data_in1, data_in0};
   assign lane_strobe = {strobe_in3, strobe_in2, strobe_in1, strobe_in0};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      secure_rx_lane #(.GAP_MAX(GAP_MAX)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .data      (lane_data[g]),
         .strobe    (lane_strobe[g]),
         .grant     (grant[g]),
         .full      (full[g]),
         .nibble    (lane_nibble[g]),
         .corrected (lane_corr[g]),
         .overflow  (overflow_out[g]),
         .timeout   (timeout_out[g]),
         .err       (err_out[g])
      );
   end

   // First full lane at or after rr_ptr, granted only when the output can take it
   always_comb begin
      out_free = !out_bus.valid_out || out_bus.ready_in;
      any_full = 1'b0;
      pick     = rr_ptr;
      idx      = rr_ptr;
      grant    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = rr_ptr + 2'(i);
         if (!any_full && full[idx]) begin
            any_full = 1'b1;
            pick     = idx;
         end
      end
      if (out_free && any_full) begin
         grant[pick] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bus.valid_out     <= 1'b0;
         out_bus.data_out      <= '0;
         out_bus.corrected_out <= 1'b0;
         rr_ptr                <= '0;
      end else if (out_free) begin
         out_bus.valid_out <= any_full;
         if (any_full) begin
            out_bus.data_out      <= {pick, lane_nibble[pick]};
            out_bus.corrected_out <= lane_corr[pick];
            rr_ptr                <= pick + 2'd1;
         end
      end
   end

endmodule
